aes_tur_denetleyici: RTL and testbench

//  Iterative round sequencer for the AES encryption datapath: drives one shared round unit (anaModul-style) through
//  TUR_SAYISI rounds instead of an unrolled chain. Latches block+key on a valid/ready handshake, feeds

---
 rtl/aes_tur_denetleyici.sv | 148 ++++++++++++++
 tb/tb_aes_tur_denetleyici.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_tur_denetleyici.sv
// ============================================================================
// Module      : aes_tur_denetleyici
// Description : Iterative AES round sequencer that drives one shared round
//               unit through TUR_SAYISI rounds per block, with input and
//               output valid/ready handshakes. Define TAMAMLANAN_SAYAC_EN to
//               add the 16-bit completed-transfer counter port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_tur_denetleyici #(
    parameter int GENISLIK    = 128,
    parameter int TUR_SAYISI  = 10,
    parameter int TUR_GECIKME = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [GENISLIK-1:0] blok,
    input  logic [GENISLIK-1:0] anahtar,
    input  logic                g_gecerli,
    output logic                hazir,
    output logic [GENISLIK-1:0] sifre,
    output logic                c_gecerli,
    input  logic                c_hazir,
    output logic                tur_gecerli,
    output logic [3:0]          tur_j,
    output logic [GENISLIK-1:0] tur_blok,
    output logic [GENISLIK-1:0] tur_anahtar,
    input  logic [GENISLIK-1:0] tur_sifre,
    input  logic [GENISLIK-1:0] tur_anahtari
`ifdef TAMAMLANAN_SAYAC_EN
    ,
    output logic [15:0]         tamamlanan
`endif
);

    localparam int BEKLE_W = (TUR_GECIKME > 1) ? $clog2(TUR_GECIKME) : 1;

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] ISLE  = 2'd1;
    localparam logic [1:0] CIKIS = 2'd2;

    localparam logic [BEKLE_W-1:0] BEKLE_SON = BEKLE_W'(TUR_GECIKME - 1);
    localparam logic [3:0]         TUR_SON   = 4'(TUR_SAYISI - 1);

    logic [1:0]          state_q,       state_d;
    logic [3:0]          tur_j_q,       tur_j_d;
    logic [BEKLE_W-1:0]  bekle_q,       bekle_d;
    logic [GENISLIK-1:0] tur_blok_q,    tur_blok_d;
    logic [GENISLIK-1:0] tur_anahtar_q, tur_anahtar_d;
    logic [GENISLIK-1:0] sifre_q,       sifre_d;
`ifdef TAMAMLANAN_SAYAC_EN
    logic [15:0]         tamamlanan_q,  tamamlanan_d;
`endif

    always_ff @(posedge clk) begin : p_durum
        if (!rst) begin
            state_q       <= BOSTA;
            tur_j_q       <= '0;
            bekle_q       <= '0;
            tur_blok_q    <= '0;
            tur_anahtar_q <= '0;
            sifre_q       <= '0;
`ifdef TAMAMLANAN_SAYAC_EN
            tamamlanan_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tur_j_q       <= tur_j_d;
            bekle_q       <= bekle_d;
            tur_blok_q    <= tur_blok_d;
            tur_anahtar_q <= tur_anahtar_d;
            sifre_q       <= sifre_d;
`ifdef TAMAMLANAN_SAYAC_EN
            tamamlanan_q  <= tamamlanan_d;
`endif
        end
    end

    always_comb begin : p_sonraki
        state_d       = state_q;
        tur_j_d       = tur_j_q;
        bekle_d       = bekle_q;
        tur_blok_d    = tur_blok_q;
        tur_anahtar_d = tur_anahtar_q;
        sifre_d       = sifre_q;
        case (state_q)
            BOSTA: begin
                if (g_gecerli) begin
                    tur_blok_d    = blok;
                    tur_anahtar_d = anahtar;
                    tur_j_d       = '0;
                    bekle_d       = '0;
                    state_d       = ISLE;
                end
            end
            ISLE: begin
                // Round outputs are only trusted once the unit has had TUR_GECIKME cycles
                if (bekle_q == BEKLE_SON) begin
                    tur_blok_d    = tur_sifre;
                    tur_anahtar_d = tur_anahtari;
                    bekle_d       = '0;
                    if (tur_j_q == TUR_SON) begin
                        sifre_d = tur_sifre;
                        state_d = CIKIS;
                    end else begin
                        tur_j_d = tur_j_q + 4'd1;
                    end
                end else begin
                    bekle_d = bekle_q + 1'b1;
                end
            end
            CIKIS: begin
                if (c_hazir) begin
                    state_d = BOSTA;
                end
            end
            default: begin
                state_d = BOSTA;
            end
        endcase
    end

`ifdef TAMAMLANAN_SAYAC_EN
    always_comb begin : p_sayac
        tamamlanan_d = tamamlanan_q;
        if ((state_q == CIKIS) && c_hazir) begin
            tamamlanan_d = tamamlanan_q + 16'd1;
        end
    end

    assign tamamlanan = tamamlanan_q;
`endif

    always_comb begin : p_cikis
        hazir       = (state_q == BOSTA);
        c_gecerli   = (state_q == CIKIS);
        tur_gecerli = (state_q == ISLE);
    end

    assign sifre       = sifre_q;
    assign tur_j       = tur_j_q;
    assign tur_blok    = tur_blok_q;
    assign tur_anahtar = tur_anahtar_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_tur_denetleyici.sv
// ============================================================================
// Module      : tb_aes_tur_denetleyici
// Description : Bench for aes_tur_denetleyici: a default instance driving a
//               behavioural AES-128 round unit and a TUR_GECIKME=2 instance
//               driving an increment stub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_tur_denetleyici;

    typedef struct {
        logic [127:0] blok;
        logic [127:0] anahtar;
        logic [127:0] beklenen;
        int           bekleme;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] blok, anahtar, sifre, tur_blok, tur_anahtar, tur_sifre, tur_anahtari;
    logic         g_gecerli, hazir, c_gecerli, c_hazir, tur_gecerli;
    logic [3:0]   tur_j;

    logic [127:0] blok2, anahtar2, sifre2, tur_blok2, tur_anahtar2, tur_sifre2, tur_anahtari2;
    logic         g_gecerli2, hazir2, c_gecerli2, c_hazir2, tur_gecerli2;
    logic [3:0]   tur_j2;
`ifdef TAMAMLANAN_SAYAC_EN
    logic [15:0]  tamamlanan, tamamlanan2;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    aes_tur_denetleyici u_dut (
        .clk(clk), .rst(rst), .blok(blok), .anahtar(anahtar),
        .g_gecerli(g_gecerli), .hazir(hazir), .sifre(sifre),
        .c_gecerli(c_gecerli), .c_hazir(c_hazir), .tur_gecerli(tur_gecerli),
        .tur_j(tur_j), .tur_blok(tur_blok), .tur_anahtar(tur_anahtar),
        .tur_sifre(tur_sifre), .tur_anahtari(tur_anahtari)
`ifdef TAMAMLANAN_SAYAC_EN
        , .tamamlanan(tamamlanan)
`endif
    );

    aes_tur_denetleyici #(.TUR_GECIKME(2)) u_dut2 (
        .clk(clk), .rst(rst), .blok(blok2), .anahtar(anahtar2),
        .g_gecerli(g_gecerli2), .hazir(hazir2), .sifre(sifre2),
        .c_gecerli(c_gecerli2), .c_hazir(c_hazir2), .tur_gecerli(tur_gecerli2),
        .tur_j(tur_j2), .tur_blok(tur_blok2), .tur_anahtar(tur_anahtar2),
        .tur_sifre(tur_sifre2), .tur_anahtari(tur_anahtari2)
`ifdef TAMAMLANAN_SAYAC_EN
        , .tamamlanan(tamamlanan2)
`endif
    );

    // ---------------- AES-128 round unit model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (a != 8'h00 && gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] anahtar_genislet(input logic [127:0] k, input logic [3:0] j);
        logic [7:0]  rc;
        logic [31:0] w3, t, n0, n1, n2, n3;
        case (j)
            4'd0: rc = 8'h01;  4'd1: rc = 8'h02;  4'd2: rc = 8'h04;  4'd3: rc = 8'h08;
            4'd4: rc = 8'h10;  4'd5: rc = 8'h20;  4'd6: rc = 8'h40;  4'd7: rc = 8'h80;
            4'd8: rc = 8'h1b;  4'd9: rc = 8'h36;  default: rc = 8'h00;
        endcase
        w3 = k[31:0];
        t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_tur(input logic [127:0] s, input logic [127:0] k,
                                             input logic [3:0] j);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] x, r;
        x = s ^ k;
        for (int i = 0; i < 16; i++) a[i] = sb(x[127-8*i -: 8]);
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++) b[rr+4*c] = a[rr + 4*((c+rr)%4)];
        for (int c = 0; c < 4; c++) begin
            if (j != 4'd9) begin
                a[4*c]   = gmul(b[4*c],2) ^ gmul(b[4*c+1],3) ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+1] = b[4*c] ^ gmul(b[4*c+1],2) ^ gmul(b[4*c+2],3) ^ b[4*c+3];
                a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2],2) ^ gmul(b[4*c+3],3);
                a[4*c+3] = gmul(b[4*c],3) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3],2);
            end else begin
                for (int q = 0; q < 4; q++) a[4*c+q] = b[4*c+q];
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
        if (j == 4'd9) r = r ^ anahtar_genislet(k, j);
        return r;
    endfunction

    assign tur_sifre     = aes_tur(tur_blok, tur_anahtar, tur_j);
    assign tur_anahtari  = anahtar_genislet(tur_anahtar, tur_j);
    assign tur_sifre2    = tur_blok2 + 128'd1;
    assign tur_anahtari2 = tur_anahtar2 + 128'd1;

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic wait_hazir(input bit ikinci);
        int n = 0;
        while (((ikinci ? hazir2 : hazir) !== 1'b1) && n < 50) begin
            tick();
            n++;
        end
        chk("hazir_timeout", {127'd0, (ikinci ? hazir2 : hazir)}, 128'd1);
    endtask

    task automatic run_aes(input vec_t v);
        wait_hazir(1'b0);
        blok = v.blok; anahtar = v.anahtar; g_gecerli = 1'b1;
        tick();
        g_gecerli = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("tur_j", tur_j, k);
            chk("tur_gecerli", tur_gecerli, 1);
            chk("c_gecerli_erken", c_gecerli, 0);
            tick();
        end
        chk("c_gecerli", c_gecerli, 1);
        chk("sifre", sifre, v.beklenen);
        for (int h = 0; h < v.bekleme; h++) begin
            g_gecerli = h[0];
            blok      = ~v.blok;
            tick();
            chk("bp_hazir", hazir, 0);
            chk("bp_c_gecerli", c_gecerli, 1);
            chk("bp_sifre", sifre, v.beklenen);
            chk("bp_tur_blok", tur_blok, v.beklenen);
        end
        g_gecerli = 1'b0;
        c_hazir   = 1'b1;
        tick();
        c_hazir = 1'b0;
        exp_cnt++;
        chk("hazir_sonra", hazir, 1);
        chk("c_gecerli_sonra", c_gecerli, 0);
        chk("sifre_tutulur", sifre, v.beklenen);
    endtask

    task automatic run_stub(input vec_t v);
        wait_hazir(1'b1);
        blok2 = v.blok; anahtar2 = v.anahtar; g_gecerli2 = 1'b1;
        tick();
        g_gecerli2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int h = 0; h < 2; h++) begin
                chk("stub_tur_j", tur_j2, k);
                chk("stub_c_gecerli_erken", c_gecerli2, 0);
                tick();
            end
        end
        chk("stub_c_gecerli", c_gecerli2, 1);
        chk("stub_sifre", sifre2, v.beklenen);
        c_hazir2 = 1'b1;
        tick();
        c_hazir2 = 1'b0;
        chk("stub_hazir_sonra", hazir2, 1);
    endtask

    // ---------------- test sequence ----------------
    vec_t aes_vec [3];
    vec_t stub_vec [4];

    initial begin
        aes_vec[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                       128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};
        aes_vec[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                       128'h3925841d02dc09fbdc118597196a0b32, 20};
        aes_vec[2] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                       128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2};
        stub_vec[0] = '{128'h0, 128'h0, 128'h0000000000000000000000000000000a, 0};
        stub_vec[1] = '{{128{1'b1}}, 128'h5, 128'h00000000000000000000000000000009, 0};
        stub_vec[2] = '{128'h0123456789abcdef0000000000000000, 128'h0,
                        128'h0123456789abcdef000000000000000a, 0};
        stub_vec[3] = '{128'h00000000000000000000000000fffffa, 128'h0,
                        128'h00000000000000000000000001000004, 0};

        rst = 1'b0; g_gecerli = 1'b1; c_hazir = 1'b0; blok = aes_vec[0].blok; anahtar = aes_vec[0].anahtar;
        g_gecerli2 = 1'b1; c_hazir2 = 1'b0; blok2 = 128'h1; anahtar2 = 128'h0;

        // Reset held with valid asserted: nothing may be accepted
        repeat (3) tick();
        chk("rst_hazir", hazir, 1);
        chk("rst_c_gecerli", c_gecerli, 0);
        chk("rst_sifre", sifre, 0);
        chk("rst_tur_gecerli", tur_gecerli, 0);
        chk("rst_tur_j", tur_j, 0);
        chk("rst_tur_blok", tur_blok, 0);
        chk("rst_tur_anahtar", tur_anahtar, 0);
        chk("rst_hazir2", hazir2, 1);
        rst = 1'b1; g_gecerli = 1'b0; g_gecerli2 = 1'b0;
        tick();
        chk("rst_birakma_hazir", hazir, 1);

        for (int i = 0; i < 3; i++) run_aes(aes_vec[i]);

        // Reset mid-block at round 5
        wait_hazir(1'b0);
        blok = aes_vec[1].blok; anahtar = aes_vec[1].anahtar; g_gecerli = 1'b1;
        tick();
        g_gecerli = 1'b0;
        repeat (5) tick();
        chk("orta_tur_j", tur_j, 5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_cnt = 0;
        chk("orta_rst_hazir", hazir, 1);
        chk("orta_rst_c_gecerli", c_gecerli, 0);
        chk("orta_rst_tur_gecerli", tur_gecerli, 0);
        chk("orta_rst_tur_j", tur_j, 0);
        begin
            int gorulen = 0;
            c_hazir = 1'b1;
            for (int n = 0; n < 15; n++) begin
                tick();
                if (c_gecerli) gorulen++;
            end
            c_hazir = 1'b0;
            chk("sahte_cikis", gorulen, 0);
        end
        run_aes(aes_vec[1]);

        for (int i = 0; i < 4; i++) run_stub(stub_vec[i]);

`ifdef TAMAMLANAN_SAYAC_EN
        run_aes(aes_vec[0]);
        run_aes(aes_vec[2]);
        chk("tamamlanan_3", tamamlanan, 128'(exp_cnt));
        chk("tamamlanan_3_sabit", tamamlanan, 3);
        u_dut.tamamlanan_q = 16'hFFFF;
        run_aes(aes_vec[0]);
        chk("tamamlanan_tasma", tamamlanan, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
